// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed LATENCY, one-cycle response.
// Optional misalignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } stateType;

    stateType state, nextState;

    logic [15:0]       mem [0:(1 << MEM_AW) - 1];
    logic [3:0]        count;
    logic              wrQ;
    logic [MEM_AW-1:0] idxQ;
    logic [15:0]       wdataQ;
    logic              misQ;

    logic              accept;
    logic              enterResp;
    logic              misIn;
    logic              unusedAddr;
    logic              curWr;
    logic              curMis;
    logic [MEM_AW-1:0] curIdx;
    logic [15:0]       curWdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign misIn      = req_addr[0];
    assign unusedAddr = ^req_addr[15:MEM_AW+1];
`else
    assign misIn      = 1'b0;
    assign unusedAddr = ^{req_addr[15:MEM_AW+1], req_addr[0]};
`endif

    // With LATENCY==1 the RESP entry coincides with the accept edge, so the
    // request fields come straight from the inputs rather than the latches.
    always_comb begin
        if (state == IDLE) begin
            curWr    = req_wr;
            curMis   = misIn;
            curIdx   = req_addr[MEM_AW:1];
            curWdata = req_wdata;
        end else begin
            curWr    = wrQ;
            curMis   = misQ;
            curIdx   = idxQ;
            curWdata = wdataQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        enterResp  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (count == 4'd1) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wrQ        <= 1'b0;
            idxQ       <= '0;
            wdataQ     <= '0;
            misQ       <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                count  <= 4'(LATENCY - 1);
                wrQ    <= req_wr;
                idxQ   <= req_addr[MEM_AW:1];
                wdataQ <= req_wdata;
                misQ   <= misIn;
            end else if (state == BUSY) begin
                count <= count - 4'd1;
            end
            if (enterResp) begin
                resp_rdata <= (curWr || curMis) ? '0 : mem[curIdx];
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)            resp_err <= 1'b0;
        else if (enterResp) resp_err <= curMis;
    end
`else
    assign resp_err = 1'b0;
`endif

    // Array is never reset; a reset on the RESP entry edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && curWr && !curMis) begin
            mem[curIdx] <= curWdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=4, MEM_AW=12).
module tb_data_mem_responder;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(
        .MEM_AW (12),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction with cycle-exact checks; inputs are scrambled after accept.
    task automatic runReq(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] expRdata,
                          input logic expErr);
        check({tag, ".ready_idle"}, {15'd0, req_ready}, 16'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        for (int unsigned k = 1; k <= LAT; k++) begin
            check({tag, ".ready_busy"}, {15'd0, req_ready}, 16'd0);
            check({tag, ".valid"}, {15'd0, resp_valid}, (k == LAT) ? 16'd1 : 16'd0);
            if (k == LAT) begin
                check({tag, ".rdata"}, resp_rdata, expRdata);
                check({tag, ".err"}, {15'd0, resp_err}, {15'd0, expErr});
            end
            tick();
        end
        check({tag, ".ready_after"}, {15'd0, req_ready}, 16'd1);
        check({tag, ".valid_after"}, {15'd0, resp_valid}, 16'd0);
    endtask

    initial begin
        logic [9:0] rdyVec;
        logic [9:0] valVec;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset.ready", {15'd0, req_ready}, 16'd1);
        check("reset.valid", {15'd0, resp_valid}, 16'd0);
        check("reset.rdata", resp_rdata, 16'h0000);
        check("reset.err", {15'd0, resp_err}, 16'd0);

        // Basic write then read-back
        runReq("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        runReq("rd_beef", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);

        // req_valid held high: accepts every LAT+1 edges, BUSY-time input changes ignored
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h1111;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                req_addr  = 16'h0042;
                req_wdata = 16'h2222;
            end
            if (i == 5) begin
                req_addr  = 16'h0044;
                req_wdata = 16'h3333;
            end
            rdyVec[i] = req_ready;
            valVec[i] = resp_valid;
        end
        req_valid = 1'b0;
        check("b2b.ready_vec", {6'd0, rdyVec}, 16'b0000_0010_0001_0000);
        check("b2b.valid_vec", {6'd0, valVec}, 16'b0000_0001_0000_1000);
        runReq("b2b_rd0", 1'b0, 16'h0040, 16'h0000, 16'h1111, 1'b0);
        runReq("b2b_rd1", 1'b0, 16'h0042, 16'h0000, 16'h2222, 1'b0);

        // Upper address bits alias onto the same word
        runReq("alias_wr0", 1'b1, 16'h0002, 16'h1234, 16'h0000, 1'b0);
        runReq("alias_wr1", 1'b1, 16'h2002, 16'h5555, 16'h0000, 1'b0);
        runReq("alias_rd", 1'b0, 16'h0002, 16'h0000, 16'h5555, 1'b0);
        runReq("alias_rd_hi", 1'b0, 16'hE002, 16'h0000, 16'h5555, 1'b0);

        // Reset mid-BUSY aborts a pending write
        runReq("abort_pre_wr", 1'b1, 16'h0020, 16'h0BAD, 16'h0000, 1'b0);
        runReq("abort_pre_rd", 1'b0, 16'h0020, 16'h0000, 16'h0BAD, 1'b0);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hAAAA;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.ready", {15'd0, req_ready}, 16'd1);
        check("abort.valid", {15'd0, resp_valid}, 16'd0);
        check("abort.rdata", resp_rdata, 16'h0000);
        for (int unsigned i = 0; i < LAT + 1; i++) begin
            check("abort.no_valid", {15'd0, resp_valid}, 16'd0);
            tick();
        end
        runReq("abort_rd", 1'b0, 16'h0020, 16'h0000, 16'h0BAD, 1'b0);

        // Reset and req_valid on the same edge: request dropped
        rst       = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'hCCCC;
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        for (int unsigned i = 0; i < LAT + 1; i++) begin
            check("rstreq.ready", {15'd0, req_ready}, 16'd1);
            check("rstreq.valid", {15'd0, resp_valid}, 16'd0);
            tick();
        end
        runReq("rstreq_rd", 1'b0, 16'h0020, 16'h0000, 16'h0BAD, 1'b0);

        // Misaligned access
        runReq("mis_pre_wr", 1'b1, 16'h0030, 16'h1010, 16'h0000, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        runReq("mis_wr", 1'b1, 16'h0031, 16'h7777, 16'h0000, 1'b1);
        runReq("mis_rd_aligned", 1'b0, 16'h0030, 16'h0000, 16'h1010, 1'b0);
        runReq("mis_rd", 1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b1);
`else
        runReq("mis_wr", 1'b1, 16'h0031, 16'h7777, 16'h0000, 1'b0);
        runReq("mis_rd_aligned", 1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0);
        runReq("mis_rd", 1'b0, 16'h0031, 16'h0000, 16'h7777, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
